// File: rtl/cpu_pkg.sv
// Shared CPU-side types and helpers: word geometry, load/store unit states and
// big-endian lane extraction.
package cpu_pkg;

  localparam int WORD_W         = 24;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } lsu_state_t;

  // Lane 0 is the most significant byte of the word.
  function automatic logic [BYTE_W-1:0] be_byte(input logic [WORD_W-1:0] word,
                                                input logic [1:0]        idx);
    case (idx)
      2'd0:    be_byte = word[23:16];
      2'd1:    be_byte = word[15:8];
      2'd2:    be_byte = word[7:0];
      default: be_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte lane steering for the load/store unit: picks the outgoing store byte and
// merges an incoming load byte into the partially assembled word.
module lsu_byte_lane
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] store_word,
  input  logic [1:0]        store_idx,
  output logic [BYTE_W-1:0] store_byte,
  input  logic [WORD_W-1:0] load_word,
  input  logic [1:0]        load_idx,
  input  logic [BYTE_W-1:0] load_byte,
  output logic [WORD_W-1:0] load_merged
);

  // Store lane select and big-endian load lane insert.
  always_comb begin
    store_byte  = be_byte(store_word, store_idx);
    load_merged = load_word;
    case (load_idx)
      2'd0:    load_merged[23:16] = load_byte;
      2'd1:    load_merged[15:8]  = load_byte;
      2'd2:    load_merged[7:0]   = load_byte;
      default: load_merged        = load_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: serialises one 24-bit request into three big-endian byte
// transactions on the byte-wide data memory port and returns word plus status.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH = 128,
  parameter int ADDR_W    = 24
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddress,
  input  logic [WORD_W-1:0] ReqWriteData,
  output logic              RespValid,
  output logic              RespError,
  output logic [WORD_W-1:0] RespReadData,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [BYTE_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic              MemReady,
  input  logic [BYTE_W-1:0] MemReadData
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - BYTES_PER_WORD);

  lsu_state_t        state_r, state_s;
  logic [1:0]        byte_r, byte_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [WORD_W-1:0] wdata_r, wdata_s;
  logic              write_r, write_s;
  logic [WORD_W-1:0] result_r, result_s;

  logic              req_ready_r, req_ready_s;
  logic              resp_valid_r, resp_valid_s;
  logic              resp_error_r, resp_error_s;
  logic [WORD_W-1:0] resp_rdata_r, resp_rdata_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [BYTE_W-1:0] mem_wdata_r, mem_wdata_s;
  logic              mem_write_r, mem_write_s;
  logic              mem_read_r, mem_read_s;

  logic [WORD_W-1:0] lane_word_s;
  logic [1:0]        lane_idx_s;
  logic [BYTE_W-1:0] lane_byte_s;
  logic [WORD_W-1:0] merged_s;

  // The first byte comes straight from the request; later bytes from the captured word.
  always_comb begin
    if (state_r == IDLE) begin
      lane_word_s = ReqWriteData;
      lane_idx_s  = 2'd0;
    end else begin
      lane_word_s = wdata_r;
      lane_idx_s  = byte_r + 2'd1;
    end
  end

  lsu_byte_lane u_lane (
    .store_word  (lane_word_s),
    .store_idx   (lane_idx_s),
    .store_byte  (lane_byte_s),
    .load_word   (result_r),
    .load_idx    (byte_r),
    .load_byte   (MemReadData),
    .load_merged (merged_s)
  );

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_s      = state_r;
    byte_s       = byte_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    write_s      = write_r;
    result_s     = result_r;
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    resp_error_s = 1'b0;
    resp_rdata_s = {WORD_W{1'b0}};
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_wdata_s  = {BYTE_W{1'b0}};
    mem_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ReqValid && req_ready_r) begin
          addr_s   = ReqAddress;
          write_s  = ReqWrite;
          wdata_s  = ReqWriteData;
          result_s = {WORD_W{1'b0}};
          byte_s   = 2'd0;
          if (ReqAddress > LAST_ADDR) begin
            state_s      = ERR;
            resp_valid_s = 1'b1;
            resp_error_s = 1'b1;
          end else begin
            state_s     = ACCESS;
            mem_addr_s  = ReqAddress;
            mem_write_s = ReqWrite;
            mem_read_s  = !ReqWrite;
            mem_wdata_s = ReqWrite ? lane_byte_s : 8'h00;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ACCESS: begin
        if (MemReady) begin
          if (!write_r) begin
            result_s = merged_s;
          end else begin
            result_s = result_r;
          end
          if (byte_r == 2'd2) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_rdata_s = write_r ? {WORD_W{1'b0}} : merged_s;
          end else begin
            byte_s      = byte_r + 2'd1;
            mem_addr_s  = addr_r + {{(ADDR_W-2){1'b0}}, byte_s};
            mem_write_s = write_r;
            mem_read_s  = !write_r;
            mem_wdata_s = write_r ? lane_byte_s : 8'h00;
          end
        end else begin
          mem_addr_s  = mem_addr_r;
          mem_wdata_s = mem_wdata_r;
          mem_write_s = mem_write_r;
          mem_read_s  = mem_read_r;
        end
      end
      RESP: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
      ERR: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
      default: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset drops every strobe immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r      <= IDLE;
      byte_r       <= 2'd0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {WORD_W{1'b0}};
      write_r      <= 1'b0;
      result_r     <= {WORD_W{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_rdata_r <= {WORD_W{1'b0}};
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {BYTE_W{1'b0}};
      mem_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      byte_r       <= byte_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      write_r      <= write_s;
      result_r     <= result_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_error_r <= resp_error_s;
      resp_rdata_r <= resp_rdata_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      mem_write_r  <= mem_write_s;
      mem_read_r   <= mem_read_s;
    end
  end

  assign ReqReady     = req_ready_r;
  assign RespValid    = resp_valid_r;
  assign RespError    = resp_error_r;
  assign RespReadData = resp_rdata_r;
  assign MemAddress   = mem_addr_r;
  assign MemWriteData = mem_wdata_r;
  assign MemWrite     = mem_write_r;
  assign MemRead      = mem_read_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of requests against a byte
// memory model, plus hand sequences for busy requests and reset mid-store.
module tb_load_store_unit;
  import cpu_pkg::*;

  localparam int MEM_DEPTH = 128;
  localparam int ADDR_W    = 24;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddress;
  logic [23:0]       ReqWriteData;
  logic              RespValid;
  logic              RespError;
  logic [23:0]       RespReadData;
  logic [ADDR_W-1:0] MemAddress;
  logic [7:0]        MemWriteData;
  logic              MemWrite;
  logic              MemRead;
  logic              MemReady;
  logic [7:0]        MemReadData;

  load_store_unit #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddress(ReqAddress), .ReqWriteData(ReqWriteData),
    .RespValid(RespValid), .RespError(RespError), .RespReadData(RespReadData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemReady(MemReady), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  // Byte memory model: writes complete on an edge with MemReady, reads are combinational.
  logic [7:0] mem [0:MEM_DEPTH-1];
  always @(posedge Clock) begin
    if (MemWrite && MemReady && (MemAddress < 24'(MEM_DEPTH)))
      mem[MemAddress[6:0]] <= MemWriteData;
  end
  assign MemReadData = (MemRead && (MemAddress < 24'(MEM_DEPTH))) ? mem[MemAddress[6:0]] : 8'h00;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [23:0] strobe_addr_q[$];
  logic [23:0] done_addr_q[$];
  logic [7:0]  done_data_q[$];
  int          lat_o;
  logic        err_o;
  logic [23:0] rdata_o;

  // Issue one request, then watch up to 30 cycles for the response.
  task automatic do_req(input logic wr, input logic [23:0] addr, input logic [23:0] wdata,
                        input logic [31:0] stall);
    strobe_addr_q.delete();
    done_addr_q.delete();
    done_data_q.delete();
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = wr; ReqAddress = addr; ReqWriteData = wdata;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0; ReqAddress = 24'h0; ReqWriteData = 24'h0; ReqWrite = 1'b0;
    lat_o = -1; err_o = 1'b0; rdata_o = 24'h0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clock);
      MemReady = !stall[c];
      if (MemRead || MemWrite) begin
        strobe_addr_q.push_back(MemAddress);
        if (MemReady) begin
          done_addr_q.push_back(MemAddress);
          done_data_q.push_back(MemWriteData);
        end
      end
      if (RespValid) begin
        lat_o = c; err_o = RespError; rdata_o = RespReadData;
        break;
      end
    end
    MemReady = 1'b1;
    if (lat_o < 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got none expected RespValid within 30 cycles");
    end
  endtask

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic [31:0] stall;
    int          exp_lat;
    logic        exp_err;
    logic [23:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    logic [7:0] exp_b;
    vecs[0]  = '{1'b1, 24'h000010, 24'hA1B2C3, 32'h0, 4, 1'b0, 24'h000000};
    vecs[1]  = '{1'b0, 24'h000010, 24'h000000, 32'h0, 4, 1'b0, 24'hA1B2C3};
    vecs[2]  = '{1'b1, 24'h000020, 24'h5A6B7C, 32'h0, 4, 1'b0, 24'h000000};
    vecs[3]  = '{1'b0, 24'h000020, 24'h000000, 32'hC, 6, 1'b0, 24'h5A6B7C};
    vecs[4]  = '{1'b1, 24'h000000, 24'h123456, 32'h0, 4, 1'b0, 24'h000000};
    vecs[5]  = '{1'b0, 24'h000000, 24'h000000, 32'h0, 4, 1'b0, 24'h123456};
    vecs[6]  = '{1'b1, 24'd125,    24'hCAFE01, 32'h0, 4, 1'b0, 24'h000000};
    vecs[7]  = '{1'b0, 24'd125,    24'h000000, 32'h0, 4, 1'b0, 24'hCAFE01};
    vecs[8]  = '{1'b0, 24'd126,    24'h000000, 32'h0, 1, 1'b1, 24'h000000};
    vecs[9]  = '{1'b1, 24'd200,    24'h777777, 32'h0, 1, 1'b1, 24'h000000};
    vecs[10] = '{1'b1, 24'h000050, 24'h9ABCDE, 32'h2, 5, 1'b0, 24'h000000};
    vecs[11] = '{1'b1, 24'h000030, 24'h000000, 32'h0, 4, 1'b0, 24'h000000};
    vecs[12] = '{1'b0, 24'hFFFFFF, 24'h000000, 32'h0, 1, 1'b1, 24'h000000};
    vecs[13] = '{1'b0, 24'h000050, 24'h000000, 32'h8, 5, 1'b0, 24'h9ABCDE};

    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddress = 24'h0;
    ReqWriteData = 24'h0; MemReady = 1'b1;
    repeat (2) @(negedge Clock);
    check("reset_outputs", {7'd0, RespValid, RespError, MemRead, MemWrite, RespReadData},
          32'h0);
    check("reset_memaddr", {8'd0, MemAddress}, 32'h0);
    Reset = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, ReqReady}, 32'h1);

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].stall);
      check($sformatf("v%0d_latency", i), lat_o, vecs[i].exp_lat);
      check($sformatf("v%0d_error", i), {31'd0, err_o}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_rdata", i), {8'd0, rdata_o}, {8'd0, vecs[i].exp_rdata});
      if (vecs[i].exp_err) begin
        check($sformatf("v%0d_no_strobe", i), strobe_addr_q.size(), 0);
      end else begin
        check($sformatf("v%0d_strobe_cycles", i), strobe_addr_q.size(), vecs[i].exp_lat - 1);
        check($sformatf("v%0d_bytes_done", i), done_addr_q.size(), 3);
        if (done_addr_q.size() == 3) begin
          for (int b = 0; b < 3; b++) begin
            check($sformatf("v%0d_addr%0d", i, b), {8'd0, done_addr_q[b]},
                  {8'd0, vecs[i].addr + 24'(b)});
            exp_b = vecs[i].wr ? 8'((vecs[i].wdata >> (16 - 8 * b)) & 24'hFF) : 8'h00;
            check($sformatf("v%0d_wdata%0d", i, b), {24'd0, done_data_q[b]}, {24'd0, exp_b});
          end
        end
        if (i == 3) begin
          held = 0;
          foreach (strobe_addr_q[k]) if (strobe_addr_q[k] == 24'h000021) held++;
          check("held_addr_21", held, 3);
        end
      end
    end

    // Busy: request kept up with a new address while the first one runs.
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddress = 24'h000040; ReqWriteData = 24'h112233;
    @(posedge Clock);
    #1;
    ReqWrite = 1'b0; ReqAddress = 24'h000050; ReqWriteData = 24'hFFFFFF;
    held = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      if (ReqReady) held++;
      if (c == 4) check("busy_first_resp", {31'd0, RespValid}, 32'h1);
    end
    check("busy_ready_low", held, 0);
    @(negedge Clock);
    check("busy_ready_cycle5", {31'd0, ReqReady}, 32'h1);
    @(posedge Clock);
    #1;
    ReqValid = 1'b0; ReqAddress = 24'h0; ReqWriteData = 24'h0;
    @(negedge Clock);
    check("busy_second_start", {6'd0, MemRead, MemWrite, MemAddress}, {2'b10, 24'h000050});
    lat_o = -1;
    for (int c = 2; c <= 30; c++) begin
      @(negedge Clock);
      if (RespValid) begin
        lat_o = c; rdata_o = RespReadData;
        break;
      end
    end
    check("busy_second_latency", lat_o, 4);
    check("busy_second_rdata", {8'd0, rdata_o}, 32'h009ABCDE);
    check("busy_first_stored", {8'd0, mem[7'h40], mem[7'h41], mem[7'h42]}, 32'h00112233);

    // Reset in cycle 2 of a store: only byte 0 lands, no response.
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddress = 24'h000030; ReqWriteData = 24'hDDEEFF;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddress = 24'h0; ReqWriteData = 24'h0;
    @(negedge Clock);
    check("abort_byte0_strobe", {7'd0, MemWrite, MemAddress}, {8'd1, 24'h000030});
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("abort_strobes", {7'd0, MemWrite, MemRead, RespValid, MemWriteData, 14'd0}, 32'h0);
    check("abort_memaddr", {8'd0, MemAddress}, 32'h0);
    held = 0;
    repeat (2) begin
      @(negedge Clock);
      if (RespValid) held++;
    end
    Reset = 1'b0;
    #1;
    check("abort_ready", {31'd0, ReqReady}, 32'h1);
    @(negedge Clock);
    if (RespValid) held++;
    check("abort_no_resp", held, 0);
    check("abort_partial_mem", {8'd0, mem[7'h30], mem[7'h31], mem[7'h32]}, 32'h00DD0000);
    do_req(1'b0, 24'h000010, 24'h0, 32'h0);
    check("post_reset_latency", lat_o, 4);
    check("post_reset_rdata", {8'd0, rdata_o}, 32'h00A1B2C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
